mac_operand_arbiter: RTL and testbench

Shares the MAC unit's single operand path between two requesters. It drives the select line of the 2-to-1 operand mux and registers the granted operand into a one-entry output stage. Both sides use valid/ready handshakes. Arbitration is round-robin with a bounded burst length, so neither requester can starve the other.

---
 rtl/mac_operand_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mac_operand_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the MAC operand path between two
// valid/ready requesters; optional per-requester beat counters via MAC_ARB_STATS_EN.
module mac_operand_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MAC_ARB_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      beats0,
  output logic [15:0]      beats1,
`endif
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  localparam logic [8:0] MAX_B = 9'(MAX_BURST);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [7:0]       burst_q, burst_d;
  logic             out_valid_q, out_valid_d;
  logic             out_src_q, out_src_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic slot_free, acc0, acc1, accept, burst_done;
  logic cur, cur_valid, oth_valid;
  logic take_en, take_idx;

  // Ready depends only on registered state and out_ready, never on reqX_valid.
  assign slot_free  = !out_valid_q || out_ready;
  assign req0_ready = (state_q == GRANT0) && slot_free;
  assign req1_ready = (state_q == GRANT1) && slot_free;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign accept     = acc0 || acc1;
  assign burst_done = ({1'b0, burst_q} + 9'd1) == MAX_B;

  assign cur       = (state_q == GRANT1);
  assign cur_valid = cur ? req1_valid : req0_valid;
  assign oth_valid = cur ? req0_valid : req1_valid;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_src_d   = acc1;
      out_data_d  = acc1 ? req1_data : req0_data;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    burst_d  = burst_q;
    take_en  = 1'b0;
    take_idx = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || last_q)) begin
        take_en  = 1'b1;
        take_idx = 1'b0;
      end else if (req1_valid) begin
        take_en  = 1'b1;
        take_idx = 1'b1;
      end
    end else if (!cur_valid) begin
      if (oth_valid) begin
        take_en  = 1'b1;
        take_idx = !cur;
      end else begin
        state_d = IDLE;
        burst_d = '0;
      end
    end else if (accept) begin
      if (burst_done) begin
        burst_d = '0;
        if (oth_valid) begin
          take_en  = 1'b1;
          take_idx = !cur;
        end
      end else begin
        burst_d = burst_q + 8'd1;
      end
    end
    // Entering a grant also covers the burst-limit and early-release handovers.
    if (take_en) begin
      state_d = take_idx ? GRANT1 : GRANT0;
      sel_d   = take_idx;
      last_d  = take_idx;
      burst_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      burst_q     <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

`ifdef MAC_ARB_STATS_EN
  logic [15:0] beats0_q, beats1_q;

  // Clear wins over a same-cycle increment; counters saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats0_q <= '0;
      beats1_q <= '0;
    end else if (stats_clr) begin
      beats0_q <= '0;
      beats1_q <= '0;
    end else begin
      if (acc0 && (beats0_q != 16'hFFFF)) beats0_q <= beats0_q + 16'd1;
      if (acc1 && (beats1_q != 16'hFFFF)) beats1_q <= beats1_q + 16'd1;
    end
  end

  assign beats0 = beats0_q;
  assign beats1 = beats1_q;
`endif

endmodule

// File: tb/tb_mac_operand_arbiter.sv
// Self-checking bench for mac_operand_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a rule-level reference model.
module tb_mac_operand_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic             req0_ready, req1_ready, out_valid, out_src, sel, busy;
  logic [WIDTH-1:0] out_data;
`ifdef MAC_ARB_STATS_EN
  logic             stats_clr = 1'b0;
  logic [15:0]      beats0, beats1;
`endif

  mac_operand_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MAC_ARB_STATS_EN
    .stats_clr(stats_clr), .beats0(beats0), .beats1(beats1),
`endif
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner of the path (-1 = nobody), run length, output slot.
  int         m_owner, m_last, m_run;
  bit         m_sel, m_ov, m_os;
  logic [7:0] m_od;
  logic [7:0] seq [2];
  logic [7:0] next_cons [2];
  int         acc_cnt [2];
  int         m_beats [2];
  bit         clr_drv = 1'b0;

  function automatic void model_reset();
    m_owner = -1; m_last = 1; m_run = 0;
    m_sel = 0; m_ov = 0; m_os = 0; m_od = '0;
    m_beats[0] = 0; m_beats[1] = 0;
    next_cons[0] = seq[0]; next_cons[1] = seq[1];
  endfunction

  function automatic void give(input int p);
    m_owner = p; m_run = 0; m_last = p; m_sel = p[0];
  endfunction

  // One clock cycle: drive, check mid-cycle, advance the model, cross the edge.
  task automatic step(input bit v0, input bit v1, input bit ord);
    bit v [2];
    bit rdy [2];
    bit acc [2];
    int x, y, s;
    v[0] = v0; v[1] = v1;
    req0_valid = v0; req1_valid = v1;
    req0_data = seq[0]; req1_data = seq[1];
    out_ready = ord;
`ifdef MAC_ARB_STATS_EN
    stats_clr = clr_drv;
`endif
    #4;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = (m_owner == k) && (!m_ov || ord);
      acc[k] = v[k] && rdy[k];
    end
    check("req0_ready", req0_ready, rdy[0]);
    check("req1_ready", req1_ready, rdy[1]);
    check("out_valid", out_valid, m_ov);
    check("sel", sel, m_sel);
    check("busy", busy, m_owner != -1);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_src", out_src, m_os);
    end
    if (m_ov && ord) begin
      check("stream_order", out_data, next_cons[m_os]);
      next_cons[m_os] = next_cons[m_os] + 8'd1;
    end
`ifdef MAC_ARB_STATS_EN
    check("beats0", beats0, m_beats[0]);
    check("beats1", beats1, m_beats[1]);
`endif
    if (acc[0] || acc[1]) begin
      s = acc[1] ? 1 : 0;
      m_od = seq[s]; m_os = s[0]; m_ov = 1;
      seq[s] = seq[s] + 8'd1;
      acc_cnt[s]++;
    end else if (m_ov && ord) begin
      m_ov = 0;
    end
    if (m_owner < 0) begin
      if (v[0] && v[1]) give(1 - m_last);
      else if (v[0]) give(0);
      else if (v[1]) give(1);
    end else begin
      x = m_owner; y = 1 - x;
      if (!v[x]) begin
        if (v[y]) give(y);
        else m_owner = -1;
      end else if (acc[x]) begin
        m_run++;
        if (m_run == MAX_BURST) begin
          m_run = 0;
          if (v[y]) give(y);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (clr_drv) m_beats[k] = 0;
      else if (acc[k] && m_beats[k] < 65535) m_beats[k]++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, base;
    seq[0] = 8'h01; seq[1] = 8'h80;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    model_reset();

    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester stream 0x01..0x0A.
    n = 0;
    while (acc_cnt[0] < 10 && n < 40) begin step(1, 0, 1); n++; end
    check("stream_done", acc_cnt[0] >= 10, 1);
    repeat (3) step(0, 0, 1);

    // Fair rotation with both requesters saturating the path.
    repeat (24) step(1, 1, 1);
    repeat (3) step(0, 0, 1);

    // Backpressure mid-burst.
    repeat (3) step(1, 0, 1);
    repeat (5) step(1, 0, 0);
    repeat (4) step(1, 0, 1);
    repeat (3) step(0, 0, 1);

    // Early release: req0 drops after two beats while req1 waits.
    step(1, 0, 1);
    step(1, 1, 1);
    step(1, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    repeat (3) step(0, 0, 1);

    // Asynchronous reset while GRANT1 holds a stalled operand.
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("pre_rst_sel", sel, 1);
    check("pre_rst_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_sel", sel, 0);
    check("async_busy", busy, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 1, 1);
    check("first_grant_sel", sel, 0);
    repeat (6) step(1, 1, 1);
    repeat (3) step(0, 0, 1);

`ifdef MAC_ARB_STATS_EN
    clr_drv = 1'b1; step(0, 0, 1); clr_drv = 1'b0;
    base = acc_cnt[0]; n = 0;
    while (acc_cnt[0] - base < 3 && n < 30) begin step(1, 0, 1); n++; end
    check("stats_req0_bound", n < 30, 1);
    repeat (2) step(0, 0, 1);
    base = acc_cnt[1]; n = 0;
    while (acc_cnt[1] - base < 5 && n < 30) begin step(0, 1, 1); n++; end
    check("stats_req1_bound", n < 30, 1);
    repeat (2) step(0, 0, 1);
    check("stats_beats0", beats0, 3);
    check("stats_beats1", beats1, 5);
    step(0, 1, 1);
    clr_drv = 1'b1; step(0, 1, 1); clr_drv = 1'b0;
    check("stats_clr_beats1", beats1, 0);
    repeat (2) step(0, 0, 1);
`endif

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
`ifdef MAC_ARB_STATS_EN
      clr_drv = ($urandom_range(0, 31) == 0);
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    clr_drv = 1'b0;
    repeat (4) step(0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
